// File: rtl/coinc_trg_pkg.sv
// Shared definitions for the coincidence trigger generator: state codes, field widths and
// a popcount helper sized for the largest supported channel count.
package coinc_trg_pkg;

  localparam int unsigned WIN_W  = 6;
  localparam int unsigned THR_W  = 4;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CH_MAX = 16;
  localparam int unsigned POP_W  = 5;

  localparam logic [1:0] StArmed   = 2'd0;
  localparam logic [1:0] StOpen    = 2'd1;
  localparam logic [1:0] StFire    = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  function automatic logic [POP_W-1:0] popcount(input logic [CH_MAX-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(CH_MAX); i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/coinc_trg_if.sv
// Hit, configuration and trigger/housekeeping bundle between the coincidence logic and
// its environment.
interface coinc_trg_if
  import coinc_trg_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 16
);

  logic [N_CH-1:0]   hit_in;
  logic [N_CH-1:0]   ch_mask_in;
  logic [WIN_W-1:0]  coinc_win_in;
  logic [THR_W-1:0]  coinc_thr_in;
  logic [HOLD_W-1:0] holdoff_in;
  logic              cnt_clr_in;
  logic              coincid_trg_out;
  logic [N_CH-1:0]   hit_pattern_out;
  logic [CNT_W-1:0]  coinc_cnt_out;

  modport master (
    output hit_in, ch_mask_in, coinc_win_in, coinc_thr_in, holdoff_in, cnt_clr_in,
    input  coincid_trg_out, hit_pattern_out, coinc_cnt_out
  );

  modport slave (
    input  hit_in, ch_mask_in, coinc_win_in, coinc_thr_in, holdoff_in, cnt_clr_in,
    output coincid_trg_out, hit_pattern_out, coinc_cnt_out
  );

endinterface

// File: rtl/hit_sync_edge.sv
// Per-channel synchroniser and rising-edge detector; SYNC_STAGES must be at least 2.
module hit_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic hit_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  // History loads 1 so a line already high at reset release never looks like an edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hit_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/coinc_trg_gen.sv
// Coincidence trigger generator: masked hit edges accumulate over a window until a majority
// threshold is met, then a one-clock trigger is issued followed by a hold-off.
module coinc_trg_gen
  import coinc_trg_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic        clk_in,
  input logic        rst_n_in,
  coinc_trg_if.slave bus
);

  logic [N_CH-1:0]   edge_raw;
  logic [N_CH-1:0]   edges;
  logic [1:0]        state_q, state_d;
  logic [N_CH-1:0]   pattern_q, pattern_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              trg_q, trg_d;
  logic [N_CH-1:0]   hit_pat_q, hit_pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              thr_on;
  logic [POP_W-1:0]  thr_ext;
  logic [POP_W-1:0]  pop_new;
  logic [POP_W-1:0]  pop_acc;
  logic [WIN_W-1:0]  win_lim;
  logic              hold_done;
  logic              fire;
  logic [N_CH-1:0]   fire_pat;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    hit_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_hit_sync_edge (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .hit_in  (bus.hit_in[i]),
      .edge_out(edge_raw[i])
    );
  end

  assign edges     = edge_raw & bus.ch_mask_in;
  assign thr_on    = (bus.coinc_thr_in != '0);
  assign thr_ext   = POP_W'(bus.coinc_thr_in);
  assign pop_new   = popcount(CH_MAX'(edges));
  assign pop_acc   = popcount(CH_MAX'(pattern_q | edges));
  assign win_lim   = (bus.coinc_win_in == '0) ? WIN_W'(1) : bus.coinc_win_in;
  assign hold_done = ((HOLD_W + 1)'(hold_cnt_q) + (HOLD_W + 1)'(1)) >=
                     (HOLD_W + 1)'(bus.holdoff_in);

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    hit_pat_d  = hit_pat_q;
    trg_d      = 1'b0;
    fire       = 1'b0;
    fire_pat   = '0;

    case (state_q)
      StArmed: begin
        if (|edges) begin
          pattern_d = edges;
          if (thr_on && (pop_new >= thr_ext)) begin
            fire     = 1'b1;
            fire_pat = edges;
          end else begin
            state_d   = StOpen;
            win_cnt_d = WIN_W'(1);
          end
        end
      end
      StOpen: begin
        // Threshold check wins over expiry when both land in the same cycle.
        if (!thr_on) begin
          state_d   = StArmed;
          pattern_d = '0;
        end else if (pop_acc >= thr_ext) begin
          fire     = 1'b1;
          fire_pat = pattern_q | edges;
        end else if (win_cnt_q >= win_lim) begin
          state_d   = StArmed;
          pattern_d = '0;
        end else begin
          pattern_d = pattern_q | edges;
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      StFire: begin
        hold_cnt_d = '0;
        state_d    = (bus.holdoff_in == '0) ? StArmed : StHoldoff;
      end
      StHoldoff: begin
        if (hold_done) begin
          state_d = StArmed;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = StArmed;
    endcase

    if (fire) begin
      state_d   = StFire;
      trg_d     = 1'b1;
      hit_pat_d = fire_pat;
      pattern_d = '0;
    end

    if (bus.cnt_clr_in) begin
      cnt_d = '0;
    end else if (fire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= StArmed;
      pattern_q  <= '0;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      trg_q      <= 1'b0;
      hit_pat_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      trg_q      <= trg_d;
      hit_pat_q  <= hit_pat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.coincid_trg_out = trg_q;
  assign bus.hit_pattern_out = hit_pat_q;
  assign bus.coinc_cnt_out   = cnt_q;

endmodule

// File: tb/tb_coinc_trg_gen.sv
// Self-checking bench for coinc_trg_gen: directed scenarios plus randomized traffic checked
// against a timestamp-based reference model.
module tb_coinc_trg_gen;

  localparam int unsigned N_CH        = 8;
  localparam int unsigned SYNC_STAGES = 2;
  // Narrow counter keeps the saturation scenario short.
  localparam int unsigned CNT_W       = 8;

  logic clk_in = 1'b0;
  logic rst_n_in;

  always #10 clk_in = ~clk_in;

  coinc_trg_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  coinc_trg_gen #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: sampled-level history, window open time and re-arm time.
  logic [N_CH-1:0]  hist [4];
  int               cyc = 0;
  int               rearm_t = 0;
  bit               win_open = 0;
  int               win_start = 0;
  logic [N_CH-1:0]  m_pat = '0;
  logic             exp_trg = 1'b0;
  logic [N_CH-1:0]  exp_pat = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic model_update();
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] acc;
    int thr;
    int win;
    bit fire;
    fire = 0;
    acc  = '0;
    if (!rst_n_in) begin
      for (int i = 0; i < 4; i++) hist[i] = '1;
      win_open = 0;
      m_pat    = '0;
      rearm_t  = 0;
      exp_trg  = 1'b0;
      exp_pat  = '0;
      exp_cnt  = '0;
      cyc++;
      return;
    end
    // An edge reaches the decision logic three clocks after the level is first sampled.
    ev  = hist[2] & ~hist[3] & bus.ch_mask_in;
    thr = int'(bus.coinc_thr_in);
    win = (bus.coinc_win_in == 0) ? 1 : int'(bus.coinc_win_in);
    if (cyc < rearm_t) begin
      // busy firing or holding off: edges are dropped
    end else if (!win_open) begin
      if (ev != 0) begin
        if (thr != 0 && $countones(ev) >= thr) begin
          fire = 1;
          acc  = ev;
        end else begin
          win_open  = 1;
          win_start = cyc;
          m_pat     = ev;
        end
      end
    end else begin
      acc = m_pat | ev;
      if (thr == 0) begin
        win_open = 0;
      end else if ($countones(acc) >= thr) begin
        fire     = 1;
        win_open = 0;
      end else if (cyc - win_start >= win) begin
        win_open = 0;
      end else begin
        m_pat = acc;
      end
    end
    if (fire) begin
      exp_pat = acc;
      rearm_t = cyc + 2 + int'(bus.holdoff_in);
    end
    exp_trg = fire;
    if (bus.cnt_clr_in) exp_cnt = '0;
    else if (fire && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = bus.hit_in;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    bus.cnt_clr_in = 1'b0;
    rst_n_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    repeat (5) tick();
  endtask

  task automatic set_cfg(input logic [7:0] mask, input logic [3:0] thr, input logic [5:0] win,
                         input logic [7:0] hold);
    bus.ch_mask_in   = mask;
    bus.coinc_thr_in = thr;
    bus.coinc_win_in = win;
    bus.holdoff_in   = hold;
  endtask

  task automatic test_reset();
    bus.hit_in = 8'($urandom);
    rst_n_in = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (bus.coincid_trg_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_trg got=%b want=0", bus.coincid_trg_out);
    end
    n_chk++;
    if (bus.hit_pattern_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_pat got=%h want=00", bus.hit_pattern_out);
    end
    n_chk++;
    if (bus.coinc_cnt_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt got=%h want=00", bus.coinc_cnt_out);
    end
    bus.hit_in = '0;
    rst_n_in = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_single_hit();
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd10);
    bus.hit_in = '0;
    do_reset();
    bus.hit_in = 8'h08;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 2) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== (j == 3)) begin
        n_fail++; $display("FAIL single_trg j=%0d got=%b want=%b", j, bus.coincid_trg_out, j == 3);
      end
    end
    n_chk++;
    if (bus.hit_pattern_out !== 8'h08) begin
      n_fail++; $display("FAIL single_pat got=%h want=08", bus.hit_pattern_out);
    end
    n_chk++;
    if (bus.coinc_cnt_out !== 8'd1) begin
      n_fail++; $display("FAIL single_cnt got=%0d want=1", bus.coinc_cnt_out);
    end
  endtask

  task automatic test_two_fold();
    set_cfg(8'hFF, 4'd2, 6'd4, 8'd10);
    bus.hit_in = '0;
    do_reset();
    bus.hit_in = 8'h01;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 1) bus.hit_in = '0;
      if (j == 2) bus.hit_in = 8'h20;
      if (j == 4) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== (j == 6)) begin
        n_fail++; $display("FAIL twofold_trg j=%0d got=%b want=%b", j, bus.coincid_trg_out, j == 6);
      end
    end
    n_chk++;
    if (bus.hit_pattern_out !== 8'h21) begin
      n_fail++; $display("FAIL twofold_pat got=%h want=21", bus.hit_pattern_out);
    end
    repeat (4) tick();
    // Second hit lands one window too late.
    bus.hit_in = 8'h01;
    for (int j = 0; j < 24; j++) begin
      tick();
      if (j == 1) bus.hit_in = '0;
      if (j == 4) bus.hit_in = 8'h20;
      if (j == 6) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== 1'b0) begin
        n_fail++; $display("FAIL late_trg j=%0d got=%b want=0", j, bus.coincid_trg_out);
      end
    end
    n_chk++;
    if (bus.hit_pattern_out !== 8'h21 || bus.coinc_cnt_out !== 8'd1) begin
      n_fail++;
      $display("FAIL late_hold pat=%h cnt=%0d want pat=21 cnt=1", bus.hit_pattern_out,
               bus.coinc_cnt_out);
    end
  endtask

  task automatic test_mask();
    set_cfg(8'hFE, 4'd1, 6'd4, 8'd10);
    bus.hit_in = '0;
    do_reset();
    bus.hit_in = 8'h01;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j == 1) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== 1'b0) begin
        n_fail++; $display("FAIL mask_off j=%0d got=%b want=0", j, bus.coincid_trg_out);
      end
    end
    bus.hit_in = 8'h02;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j == 1) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== (j == 3)) begin
        n_fail++; $display("FAIL mask_on j=%0d got=%b want=%b", j, bus.coincid_trg_out, j == 3);
      end
    end
    n_chk++;
    if (bus.hit_pattern_out !== 8'h02) begin
      n_fail++; $display("FAIL mask_pat got=%h want=02", bus.hit_pattern_out);
    end
  endtask

  task automatic test_holdoff();
    int last;
    int ntrg;
    last = -1;
    ntrg = 0;
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd10);
    bus.hit_in = '0;
    do_reset();
    for (int j = 0; j < 80; j++) begin
      bus.hit_in = (j % 4 == 0) ? 8'h04 : 8'h00;
      tick();
      n_chk++;
      if (bus.coincid_trg_out !== exp_trg || bus.hit_pattern_out !== exp_pat ||
          bus.coinc_cnt_out !== exp_cnt) begin
        n_fail++;
        $display("FAIL holdoff_model cyc=%0d trg=%b/%b pat=%h/%h cnt=%0d/%0d", cyc,
                 bus.coincid_trg_out, exp_trg, bus.hit_pattern_out, exp_pat,
                 bus.coinc_cnt_out, exp_cnt);
      end
      if (bus.coincid_trg_out === 1'b1) begin
        n_chk++;
        if (bus.hit_pattern_out !== 8'h04) begin
          n_fail++; $display("FAIL holdoff_pat got=%h want=04", bus.hit_pattern_out);
        end
        if (last >= 0) begin
          n_chk++;
          if (j - last != 12) begin
            n_fail++; $display("FAIL holdoff_gap got=%0d want=12", j - last);
          end
        end
        last = j;
        ntrg++;
      end
    end
    n_chk++;
    if (ntrg != 7) begin
      n_fail++; $display("FAIL holdoff_count got=%0d want=7", ntrg);
    end
    bus.hit_in = '0;
  endtask

  task automatic test_saturation();
    bit seen;
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd0);
    bus.hit_in = '0;
    do_reset();
    for (int j = 0; j < 600; j++) begin
      bus.hit_in[0] = ~bus.hit_in[0];
      tick();
      n_chk++;
      if (bus.coincid_trg_out !== exp_trg || bus.coinc_cnt_out !== exp_cnt) begin
        n_fail++;
        $display("FAIL sat_model cyc=%0d trg=%b/%b cnt=%0d/%0d", cyc, bus.coincid_trg_out,
                 exp_trg, bus.coinc_cnt_out, exp_cnt);
      end
    end
    n_chk++;
    if (bus.coinc_cnt_out !== 8'hFF) begin
      n_fail++; $display("FAIL sat_value got=%h want=ff", bus.coinc_cnt_out);
    end
    seen = 0;
    for (int j = 0; j < 10 && !seen; j++) begin
      bus.hit_in[0] = ~bus.hit_in[0];
      tick();
      if (bus.coincid_trg_out === 1'b1) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL sat_wait_trg got=timeout want=trigger");
    end
    bus.hit_in[0] = ~bus.hit_in[0];
    tick();
    bus.cnt_clr_in = 1'b1;
    bus.hit_in[0] = ~bus.hit_in[0];
    tick();
    bus.cnt_clr_in = 1'b0;
    n_chk++;
    if (bus.coincid_trg_out !== 1'b1 || bus.coinc_cnt_out !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_prio trg=%b cnt=%0d want trg=1 cnt=0", bus.coincid_trg_out,
               bus.coinc_cnt_out);
    end
    bus.hit_in[0] = ~bus.hit_in[0];
    tick();
    bus.hit_in[0] = ~bus.hit_in[0];
    tick();
    n_chk++;
    if (bus.coinc_cnt_out !== 8'd1) begin
      n_fail++; $display("FAIL clr_recount got=%0d want=1", bus.coinc_cnt_out);
    end
    bus.hit_in = '0;
  endtask

  task automatic test_edge_cases();
    // Line held high through reset release.
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd2);
    bus.hit_in = 8'hFF;
    do_reset();
    for (int j = 0; j < 15; j++) begin
      tick();
      n_chk++;
      if (bus.coincid_trg_out !== 1'b0) begin
        n_fail++; $display("FAIL held_high j=%0d got=%b want=0", j, bus.coincid_trg_out);
      end
    end
    // Threshold dropped to 0 while a window is open.
    set_cfg(8'hFF, 4'd2, 6'd8, 8'd2);
    bus.hit_in = '0;
    do_reset();
    bus.hit_in = 8'h01;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 1) bus.hit_in = '0;
      if (j == 2) bus.hit_in = 8'h02;
      if (j == 3) bus.coinc_thr_in = 4'd0;
      if (j == 4) begin
        bus.coinc_thr_in = 4'd2;
        bus.hit_in = '0;
      end
      n_chk++;
      if (bus.coincid_trg_out !== 1'b0) begin
        n_fail++; $display("FAIL thr0_open j=%0d got=%b want=0", j, bus.coincid_trg_out);
      end
    end
    // Reset during hold-off.
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd20);
    bus.hit_in = '0;
    do_reset();
    bus.hit_in = 8'h08;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 2) bus.hit_in = '0;
      n_chk++;
      if (bus.coincid_trg_out !== (j == 3)) begin
        n_fail++; $display("FAIL pre_rst j=%0d got=%b want=%b", j, bus.coincid_trg_out, j == 3);
      end
    end
    rst_n_in = 1'b0;
    tick();
    n_chk++;
    if (bus.coincid_trg_out !== 1'b0 || bus.hit_pattern_out !== 8'h00 ||
        bus.coinc_cnt_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_holdoff trg=%b pat=%h cnt=%0d want all 0", bus.coincid_trg_out,
               bus.hit_pattern_out, bus.coinc_cnt_out);
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] thr_tab [10];
    thr_tab = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd12};
    for (int blk = 0; blk < 8; blk++) begin
      set_cfg(8'($urandom), thr_tab[$urandom_range(0, 9)], 6'($urandom_range(0, 8)),
              8'($urandom_range(0, 6)));
      bus.hit_in = '0;
      do_reset();
      for (int j = 0; j < 400; j++) begin
        for (int c = 0; c < int'(N_CH); c++) begin
          if ($urandom_range(0, 5) == 0) bus.hit_in[c] = ~bus.hit_in[c];
        end
        if ($urandom_range(0, 31) == 0) bus.ch_mask_in = 8'($urandom);
        if ($urandom_range(0, 31) == 0) bus.coinc_thr_in = thr_tab[$urandom_range(0, 9)];
        if ($urandom_range(0, 31) == 0) bus.coinc_win_in = 6'($urandom_range(0, 8));
        bus.cnt_clr_in = ($urandom_range(0, 63) == 0);
        tick();
        n_chk++;
        if (bus.coincid_trg_out !== exp_trg || bus.hit_pattern_out !== exp_pat ||
            bus.coinc_cnt_out !== exp_cnt) begin
          n_fail++;
          $display("FAIL rand_model blk=%0d cyc=%0d trg=%b/%b pat=%h/%h cnt=%0d/%0d", blk, cyc,
                   bus.coincid_trg_out, exp_trg, bus.hit_pattern_out, exp_pat,
                   bus.coinc_cnt_out, exp_cnt);
        end
      end
      bus.cnt_clr_in = 1'b0;
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    bus.hit_in = '0;
    bus.cnt_clr_in = 1'b0;
    set_cfg(8'hFF, 4'd1, 6'd4, 8'd10);
    for (int i = 0; i < 4; i++) hist[i] = '1;
    test_reset();
    test_single_hit();
    test_two_fold();
    test_mask();
    test_holdoff();
    test_saturation();
    test_edge_cases();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
